// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if
// Memory handshake bundle between the multi-cycle controller and the
// instruction/data memories.
//   imem_req  controller -> imem   instruction fetch request
//   imem_ack  imem -> controller   instruction valid (IR captures this cycle)
//   dmem_req  controller -> dmem   data access request
//   dmem_we   controller -> dmem   1 = write, valid while dmem_req=1
//   dmem_ack  dmem -> controller   data access complete
// ---------------------------------------------------------------------------
interface multicycle_controller_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output dmem_ack
  );
endinterface

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Per-instruction sequencing FSM for the 8-bit 4-GPR datapath. Fetch and
// data accesses use req/ack so either memory may stretch an access; a run
// of TIMEOUT_CYCLES unacknowledged request cycles parks the FSM in FAULT.
//
// Ports:
//   clock       system clock (rising edge)
//   reset       synchronous, active-low
//   run         level, 1 = free-run
//   step        single-step request (rising edge detected internally)
//   opcode      IR[7:6]: 00 ADD, 01 LOAD, 10 STORE, 11 BRANCH
//   mem         memory handshake bundle (master side)
//   ir_write    load IR
//   pc_write    update PC (one pulse per instruction)
//   pc_src      0 = PC+1, 1 = PC+1+sext(IR[1:0])
//   reg_write   GPR write enable
//   reg_dst     1 = dest IR[1:0], 0 = dest IR[3:2]
//   alu_src     1 = ALU B is the sign-extended immediate
//   mem_to_reg  1 = writeback from memory read data
//   halted      1 in IDLE
//   fault       1 in FAULT
//   state       current state code
//   retired     completed-instruction count, wraps
// ---------------------------------------------------------------------------
module multicycle_controller #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     step,
  input  logic [1:0]               opcode,
  multicycle_controller_if.master  mem,
  output logic                     ir_write,
  output logic                     pc_write,
  output logic                     pc_src,
  output logic                     reg_write,
  output logic                     reg_dst,
  output logic                     alu_src,
  output logic                     mem_to_reg,
  output logic                     halted,
  output logic                     fault,
  output logic [2:0]               state,
  output logic [CNT_WIDTH-1:0]     retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_STORE  = 2'b10;
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               r_state;
  state_t               w_state_next;
  state_t               w_done_next;
  logic [1:0]           r_op;
  logic                 r_single;
  logic                 w_single_next;
  logic                 r_step_q;
  logic                 w_step_edge;
  logic [7:0]           r_wait;
  logic                 w_wait_inc;
  logic                 w_timeout;
  logic                 w_retire;
  logic [CNT_WIDTH-1:0] r_retired;
  logic                 w_imem_req;
  logic                 w_dmem_req;
  logic                 w_dmem_we;

  assign w_step_edge = step & ~r_step_q;
  // The current wait cycle is the last one allowed when the count would hit the limit.
  assign w_timeout   = (r_wait + 8'd1) == TIMEOUT_LIM;
  // Where a completed instruction goes: keep fetching only in free-run mode.
  assign w_done_next = (run && !r_single) ? S_FETCH : S_IDLE;

  always_comb begin
    w_state_next  = r_state;
    w_single_next = r_single;
    w_wait_inc    = 1'b0;
    w_retire      = 1'b0;
    w_imem_req    = 1'b0;
    w_dmem_req    = 1'b0;
    w_dmem_we     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src       = 1'b0;
    mem_to_reg    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_state_next  = S_FETCH;
          w_single_next = 1'b0;
        end else if (w_step_edge) begin
          w_state_next  = S_FETCH;
          w_single_next = 1'b1;
        end
      end

      S_FETCH: begin
        w_imem_req = 1'b1;
        if (mem.imem_ack) begin
          ir_write     = 1'b1;
          w_state_next = S_DECODE;
        end else begin
          w_wait_inc = 1'b1;
          if (w_timeout) begin
            w_state_next = S_FAULT;
          end
        end
      end

      S_DECODE: begin
        w_state_next = S_EXEC;
      end

      S_EXEC: begin
        case (r_op)
          OP_ADD: begin
            reg_dst      = 1'b1;
            w_state_next = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src      = 1'b1;
            w_state_next = S_MEM;
          end
          default: begin
            // BRANCH completes here: PC takes the relative target.
            pc_src       = 1'b1;
            pc_write     = 1'b1;
            w_retire     = 1'b1;
            w_state_next = w_done_next;
          end
        endcase
      end

      S_MEM: begin
        w_dmem_req = 1'b1;
        alu_src    = 1'b1;
        w_dmem_we  = (r_op == OP_STORE);
        if (mem.dmem_ack) begin
          if (r_op == OP_LOAD) begin
            w_state_next = S_WB;
          end else begin
            pc_write     = 1'b1;
            w_retire     = 1'b1;
            w_state_next = w_done_next;
          end
        end else begin
          w_wait_inc = 1'b1;
          if (w_timeout) begin
            w_state_next = S_FAULT;
          end
        end
      end

      S_WB: begin
        reg_write    = 1'b1;
        pc_write     = 1'b1;
        w_retire     = 1'b1;
        mem_to_reg   = (r_op == OP_LOAD);
        reg_dst      = (r_op == OP_ADD);
        alu_src      = (r_op == OP_LOAD);
        w_state_next = w_done_next;
      end

      S_FAULT: begin
        w_state_next = S_FAULT;
      end

      // Unused code 6 falls back to IDLE.
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_op      <= 2'b00;
      r_single  <= 1'b0;
      // Starts high so a step held through reset release is not an edge.
      r_step_q  <= 1'b1;
      r_wait    <= 8'd0;
      r_retired <= '0;
    end else begin
      r_state  <= w_state_next;
      r_single <= w_single_next;
      r_step_q <= step;
      if (r_state == S_DECODE) begin
        r_op <= opcode;
      end
      if (w_state_next != r_state) begin
        r_wait <= 8'd0;
      end else if (w_wait_inc) begin
        r_wait <= r_wait + 8'd1;
      end
      if (w_retire) begin
        r_retired <= r_retired + CNT_ONE;
      end
    end
  end

  assign mem.imem_req = w_imem_req;
  assign mem.dmem_req = w_dmem_req;
  assign mem.dmem_we  = w_dmem_we;
  assign halted       = (r_state == S_IDLE);
  assign fault        = (r_state == S_FAULT);
  assign state        = r_state;
  assign retired      = r_retired;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle sequencing FSM for the 8-bit 4-GPR datapath. It replaces fixed single-cycle control with per-instruction state sequencing, and handshakes with the instruction and data memories through req/ack pairs, so either memory may insert wait states. It supports free-run and single-step execution, a wait-state timeout fault, and a retired-instruction counter for the console.

Parameters:
TIMEOUT_CYCLES, 15, max consecutive cycles of req without ack before entering FAULT (range 1..255)
CNT_WIDTH, 16, width of the retired-instruction counter

Ports:
clock  in  1  system clock, all logic on its rising edge
reset  in  1  synchronous, active-low reset
run  in  1  level; 1 = free-run
step  in  1  single-step request; rising edge detected internally
opcode  in  2  IR[7:6] from the datapath IR (00 ADD, 01 LOAD, 10 STORE, 11 BRANCH)
imem_req  out  1  instruction fetch request
imem_ack  in  1  instruction valid; IR captures on this cycle
dmem_req  out  1  data memory access request
dmem_we  out  1  1 = write (STORE), valid while dmem_req=1
dmem_ack  in  1  data access complete
ir_write  out  1  load IR
pc_write  out  1  update PC
pc_src  out  1  0 = PC+1, 1 = PC+1+sext(IR[1:0])
reg_write  out  1  GPR write enable
reg_dst  out  1  1 = dest IR[1:0], 0 = dest IR[3:2]
alu_src  out  1  1 = ALU B is the sign-extended immediate
mem_to_reg  out  1  1 = writeback from memory read data
halted  out  1  1 in IDLE
fault  out  1  1 in FAULT
state  out  3  current state code
retired  out  CNT_WIDTH  instructions completed, wraps modulo 2^CNT_WIDTH

Behaviour:
- State codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7. Code 6 is unused and recovers to IDLE.
- Reset (reset=0 at a clock edge):
  - state=IDLE, retired=0, wait counter=0, single flag=0, op_q=00.
  - Step-edge register reset to 1, so a step held high through reset release is not an edge.
  - All strobes 0, halted=1, fault=0.
  - Reset overrides every state, including mid-handshake and FAULT.
- Strobe outputs are combinational from state, op_q and the acks. No strobe is asserted in IDLE or FAULT.
- IDLE:
  - run=1 → FETCH with single=0.
  - Otherwise a step rising edge → FETCH with single=1.
  - Step edges seen outside IDLE are discarded.
- FETCH:
  - imem_req=1.
  - imem_ack=1: ir_write=1 in the same cycle, → DECODE.
  - Otherwise the wait counter increments; when it reaches TIMEOUT_CYCLES → FAULT.
- DECODE: op_q <= opcode. No strobes. → EXEC.
- EXEC:
  - ADD: reg_dst=1, alu_src=0, → WB.
  - LOAD and STORE: alu_src=1, → MEM.
  - BRANCH: pc_src=1, pc_write=1, instruction retires, → completion.
- MEM:
  - dmem_req=1, alu_src=1, dmem_we=(op_q==10).
  - dmem_ack=1: LOAD → WB; STORE retires with pc_write=1, → completion.
  - No ack: wait counter increments; at TIMEOUT_CYCLES → FAULT.
- WB:
  - reg_write=1, pc_write=1, instruction retires.
  - mem_to_reg=(op_q==01), reg_dst=(op_q==00), alu_src=(op_q==01).
- Completion:
  - The retiring cycle increments retired.
  - Next state is FETCH if run=1 and single=0, else IDLE.
  - Deasserting run mid-instruction finishes the current instruction, then goes to IDLE.
- Wait counter clears on every state change.
- Latencies with zero-wait acks (ack in the first req cycle): ADD 4, LOAD 5, STORE 4, BRANCH 3 cycles. Each wait state adds one cycle.
- pc_write pulses exactly once per instruction.
- Acks arriving outside FETCH/MEM are ignored. Both acks high at once: only the one matching the current state is used.
- FAULT: fault=1, halted=0, all strobes 0. Exits only on reset.

Test Plan:
- Reset with run=0, step=1 held, then release: state=0, halted=1, retired=0; no FETCH until step goes low then high.
- run=1, acks tied to req, opcode=00: state sequence 1,2,3,5 repeating; pc_write every 4th cycle; retired=5 after 20 cycles.
- One step edge, opcode=01, dmem_ack delayed 3 cycles: dmem_req high 4 cycles, dmem_we=0; WB shows mem_to_reg=1, reg_write=1; then IDLE with retired=1.
- opcode=11 under run: EXEC asserts pc_src=1 and pc_write=1; reg_write and dmem_req never asserted; 3 cycles per instruction.
- imem_ack held 0 with TIMEOUT_CYCLES=15: fault=1 after 15 req cycles; strobes stay 0 despite later acks; reset=0 → IDLE.
- STORE with run dropped to 0 in EXEC: MEM with dmem_we=1, retire on ack, then IDLE; retired wraps 0xFFFF→0x0000 when preloaded by running 65536 instructions.
